// File: rtl/fp32_mul_round_pack.sv
// Round-and-pack back end of the FP32 multiplier: normalises the 48-bit significand
// product, rounds to nearest-even, resolves specials and packs the IEEE-754 result.
module fp32_mul_round_pack #(
  parameter int          EXP_W     = 10,
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [47:0]      product,
  input  logic [EXP_W-1:0] exp_sum,
  input  logic             sign,
  input  logic             is_nan,
  input  logic             is_inf,
  input  logic             is_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic             flag_ovf,
  output logic             flag_unf,
  output logic             flag_inx,
  output logic             flag_inv
);

  logic s1_en, s2_en;
  logic s1_valid_reg, s2_valid_reg;

  assign s2_en     = ~s2_valid_reg | out_ready;
  assign s1_en     = ~s1_valid_reg | s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_valid_reg;

  // Stage 1: pick the leading one position and split into mantissa/guard/sticky.
  logic [22:0]    mant_next;
  logic           guard_next, sticky_next, tiny_next;
  logic [EXP_W:0] exp_next;
  logic [EXP_W:0] exp_ext;

  assign exp_ext = {exp_sum[EXP_W-1], exp_sum};

  always_comb begin
    mant_next   = product[45:23];
    guard_next  = product[22];
    sticky_next = |product[21:0];
    exp_next    = exp_ext;
    if (product[47]) begin
      mant_next   = product[46:24];
      guard_next  = product[23];
      sticky_next = |product[22:0];
      exp_next    = exp_ext + (EXP_W+1)'(1);
    end
    tiny_next = ~product[47] & ~product[46] & ~(is_nan | is_inf | is_zero);
  end

  logic [22:0]    s1_mant_reg;
  logic           s1_guard_reg, s1_sticky_reg, s1_tiny_reg;
  logic [EXP_W:0] s1_exp_reg;
  logic           s1_sign_reg, s1_nan_reg, s1_inf_reg, s1_zero_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_mant_reg   <= '0;
      s1_guard_reg  <= 1'b0;
      s1_sticky_reg <= 1'b0;
      s1_tiny_reg   <= 1'b0;
      s1_exp_reg    <= '0;
      s1_sign_reg   <= 1'b0;
      s1_nan_reg    <= 1'b0;
      s1_inf_reg    <= 1'b0;
      s1_zero_reg   <= 1'b0;
    end else if (s1_en) begin
      s1_valid_reg  <= in_valid;
      s1_mant_reg   <= mant_next;
      s1_guard_reg  <= guard_next;
      s1_sticky_reg <= sticky_next;
      s1_tiny_reg   <= tiny_next;
      s1_exp_reg    <= exp_next;
      s1_sign_reg   <= sign;
      s1_nan_reg    <= is_nan;
      s1_inf_reg    <= is_inf;
      s1_zero_reg   <= is_zero;
    end
  end

  // Stage 2: round to nearest-even; a mantissa carry leaves the low 23 bits zero.
  logic           round_inc;
  logic [23:0]    mant_sum;
  logic [EXP_W+1:0] exp_rnd;
  logic [31:0]    result_next;
  logic           ovf_next, unf_next, inx_next, inv_next;

  assign round_inc = s1_guard_reg & (s1_sticky_reg | s1_mant_reg[0]);
  assign mant_sum  = {1'b0, s1_mant_reg} + 24'(round_inc);
  assign exp_rnd   = {s1_exp_reg[EXP_W], s1_exp_reg} + (EXP_W+2)'(mant_sum[23]);

  always_comb begin
    result_next = {s1_sign_reg, exp_rnd[7:0], mant_sum[22:0]};
    ovf_next    = 1'b0;
    unf_next    = 1'b0;
    inx_next    = s1_guard_reg | s1_sticky_reg;
    inv_next    = 1'b0;
    if (s1_nan_reg || (s1_inf_reg && s1_zero_reg)) begin
      result_next = CANON_NAN;
      inx_next    = 1'b0;
      inv_next    = ~s1_nan_reg;
    end else if (s1_inf_reg) begin
      result_next = {s1_sign_reg, 8'hFF, 23'h0};
      inx_next    = 1'b0;
    end else if (s1_zero_reg) begin
      result_next = {s1_sign_reg, 31'h0};
      inx_next    = 1'b0;
    end else if (s1_tiny_reg) begin
      result_next = {s1_sign_reg, 31'h0};
      unf_next    = 1'b1;
      inx_next    = 1'b0;
    end else if ($signed(exp_rnd) >= $signed((EXP_W+2)'(255))) begin
      result_next = {s1_sign_reg, 8'hFF, 23'h0};
      ovf_next    = 1'b1;
      inx_next    = 1'b1;
    end else if ($signed(exp_rnd) < $signed((EXP_W+2)'(1))) begin
      result_next = {s1_sign_reg, 31'h0};
      unf_next    = 1'b1;
      inx_next    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      result       <= '0;
      flag_ovf     <= 1'b0;
      flag_unf     <= 1'b0;
      flag_inx     <= 1'b0;
      flag_inv     <= 1'b0;
    end else if (s2_en) begin
      s2_valid_reg <= s1_valid_reg;
      result       <= result_next;
      flag_ovf     <= ovf_next;
      flag_unf     <= unf_next;
      flag_inx     <= inx_next;
      flag_inv     <= inv_next;
    end
  end

endmodule

// File: tb/tb_fp32_mul_round_pack.sv
// Bench for fp32_mul_round_pack: directed plan vectors plus randomized streaming with
// random backpressure, scored against an integer-arithmetic rounding model.
module tb_fp32_mul_round_pack;

  localparam logic [31:0] CANON = 32'h7FC00000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [47:0] product;
  logic [9:0]  exp_sum;
  logic        sign, is_nan, is_inf, is_zero;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        flag_ovf, flag_unf, flag_inx, flag_inv;

  fp32_mul_round_pack #(.EXP_W(10), .CANON_NAN(CANON)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .exp_sum(exp_sum), .sign(sign),
    .is_nan(is_nan), .is_inf(is_inf), .is_zero(is_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_ovf(flag_ovf), .flag_unf(flag_unf),
    .flag_inx(flag_inx), .flag_inv(flag_inv)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [47:0] product;
    logic [9:0]  exp_sum;
    logic        sign, is_nan, is_inf, is_zero;
  } op_t;

  typedef struct {
    op_t         op;
    bit          use_want;
    logic [35:0] want;
  } pend_t;

  pend_t       pend_q[$];
  logic [35:0] exp_q[$];
  int          acc_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          n_out    = 0;
  bit          check_lat = 0;
  bit          held_valid = 0;
  logic [35:0] held;
  logic        last_in_ready;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h", tag, got, want);
  endtask

  // Reference: value-level round-to-nearest-even on the integer product.
  function automatic logic [35:0] model(input op_t o);
    longint unsigned p, v, rem, half;
    int sh, e;
    logic inx;
    if (o.is_nan || (o.is_inf && o.is_zero)) return {CANON, 3'b000, ~o.is_nan};
    if (o.is_inf)  return {o.sign, 8'hFF, 23'd0, 4'b0000};
    if (o.is_zero) return {o.sign, 31'd0, 4'b0000};
    if (o.product[47:46] == 2'b00) return {o.sign, 31'd0, 4'b0100};
    p    = 64'(o.product);
    sh   = o.product[47] ? 24 : 23;
    v    = p >> sh;
    rem  = p - (v << sh);
    half = 64'd1 << (sh - 1);
    e    = int'($signed(o.exp_sum)) + (sh - 23);
    inx  = (rem != 0);
    if (rem > half || (rem == half && v[0])) v = v + 1;
    if (v == (64'd1 << 24)) begin
      v = v >> 1;
      e = e + 1;
    end
    if (e >= 255) return {o.sign, 8'hFF, 23'd0, 4'b1010};
    if (e <= 0)   return {o.sign, 31'd0, 4'b0110};
    return {o.sign, 8'(e), 23'(v), 1'b0, 1'b0, inx, 1'b0};
  endfunction

  function automatic op_t mk(input logic [47:0] p, input int es, input logic s,
                             input logic n, input logic i, input logic z);
    op_t o;
    o.product = p;
    o.exp_sum = 10'(es);
    o.sign    = s;
    o.is_nan  = n;
    o.is_inf  = i;
    o.is_zero = z;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int k;
    o.product = {16'($urandom), $urandom};
    k = int'($urandom_range(0, 99));
    if (k < 50)      o.product[47] = 1'b1;
    else if (k < 92) o.product[47:46] = 2'b01;
    else             o.product[47:46] = 2'b00;
    if ($urandom_range(0, 3) == 0) o.product[23:0] = 24'd0;
    k = int'($urandom_range(0, 9));
    if (k < 5)       o.exp_sum = 10'($urandom_range(100, 160));
    else if (k < 7)  o.exp_sum = 10'($urandom_range(250, 258));
    else if (k < 9)  o.exp_sum = 10'(int'($urandom_range(0, 4)) - 2);
    else             o.exp_sum = 10'($urandom);
    o.sign    = 1'($urandom);
    o.is_nan  = ($urandom_range(0, 24) == 0);
    o.is_inf  = ($urandom_range(0, 14) == 0);
    o.is_zero = ($urandom_range(0, 14) == 0);
    return o;
  endfunction

  task automatic push_op(input op_t o, input bit use_want, input logic [35:0] want);
    pend_t e;
    e.op = o;
    e.use_want = use_want;
    e.want = want;
    pend_q.push_back(e);
  endtask

  // One clock: drive at the falling edge, sample 1 ns later, score transfers due at the next rising edge.
  task automatic run_cycle(input logic ordy, input bit gap);
    logic [35:0] obs, e;
    int a;
    @(negedge clk);
    cyc++;
    out_ready = ordy;
    if (pend_q.size() > 0 && !gap) begin
      in_valid = 1'b1;
      product  = pend_q[0].op.product;
      exp_sum  = pend_q[0].op.exp_sum;
      sign     = pend_q[0].op.sign;
      is_nan   = pend_q[0].op.is_nan;
      is_inf   = pend_q[0].op.is_inf;
      is_zero  = pend_q[0].op.is_zero;
    end else begin
      in_valid = 1'b0;
    end
    #1;
    last_in_ready = in_ready;
    obs = {result, flag_ovf, flag_unf, flag_inx, flag_inv};
    if (held_valid) begin
      check("hold_valid", 36'(out_valid), 36'd1);
      check("hold_data", obs, held);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_out", 36'(out_valid), 36'd0);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        n_out++;
        $display("out %0d cyc %0d result=%h ovf=%b unf=%b inx=%b inv=%b", n_out, cyc,
                 result, flag_ovf, flag_unf, flag_inx, flag_inv);
        check("result", obs, e);
        if (check_lat) check("latency", 36'(cyc - a), 36'd2);
      end
    end
    held_valid = out_valid && !out_ready;
    held = obs;
    if (in_valid && in_ready) begin
      exp_q.push_back(pend_q[0].use_want ? pend_q[0].want : model(pend_q[0].op));
      acc_q.push_back(cyc);
      void'(pend_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    product = '0; exp_sum = '0; sign = 1'b0;
    is_nan = 1'b0; is_inf = 1'b0; is_zero = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 36'(out_valid), 36'd0);
    check("rst_in_ready", 36'(in_ready), 36'd1);
    check("rst_result", {result, flag_ovf, flag_unf, flag_inx, flag_inv}, 36'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed vectors, streamed back-to-back with no backpressure.
    push_op(mk(48'h900000000000, 127, 0, 0, 0, 0), 1, {32'h40100000, 4'b0000});
    push_op(mk(48'h400000C00000, 127, 0, 0, 0, 0), 1, {32'h3F800002, 4'b0010});
    push_op(mk(48'h400000400000, 127, 0, 0, 0, 0), 1, {32'h3F800000, 4'b0010});
    push_op(mk(48'h7FFFFFFFFFFF, 127, 0, 0, 0, 0), 1, {32'h40000000, 4'b0010});
    push_op(mk(48'h800000000000, 254, 0, 0, 0, 0), 1, {32'h7F800000, 4'b1010});
    push_op(mk(48'h400000000000, -1,  1, 0, 0, 0), 1, {32'h80000000, 4'b0110});
    push_op(mk(48'h400000000000, 127, 0, 0, 1, 1), 1, {32'h7FC00000, 4'b0001});
    push_op(mk(48'h400000000000, 127, 1, 0, 1, 0), 1, {32'hFF800000, 4'b0000});
    push_op(mk(48'h400000000000, 127, 0, 1, 0, 0), 1, {32'h7FC00000, 4'b0000});
    push_op(mk(48'h400000000000, 127, 1, 0, 0, 1), 1, {32'h80000000, 4'b0000});
    push_op(mk(48'h400000000000, 254, 0, 0, 0, 0), 1, {32'h7F000000, 4'b0000});
    push_op(mk(48'h400000000000, 1,   0, 0, 0, 0), 1, {32'h00800000, 4'b0000});
    push_op(mk(48'h400000000000, 0,   0, 0, 0, 0), 1, {32'h00000000, 4'b0110});
    push_op(mk(48'h7FFFFFFFFFFF, 254, 0, 0, 0, 0), 1, {32'h7F800000, 4'b1010});
    push_op(mk(48'h7FFFFFFFFFFF, 0,   0, 0, 0, 0), 1, {32'h00800000, 4'b0010});
    push_op(mk(48'h200000000000, 127, 1, 0, 0, 0), 1, {32'h80000000, 4'b0100});
    check_lat = 1;
    repeat (22) run_cycle(1'b1, 1'b0);
    check_lat = 0;
    check("directed_drain", 36'(exp_q.size()), 36'd0);

    // Backpressure: 4 ops, downstream stalls on cycles 3-6.
    for (int i = 0; i < 4; i++) push_op(rand_op(), 0, '0);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b0, 1'b0);
    check("bp_in_ready", 36'(last_in_ready), 36'd0);
    repeat (3) run_cycle(1'b0, 1'b0);
    check("bp_pending", 36'(pend_q.size()), 36'd2);
    repeat (10) run_cycle(1'b1, 1'b0);
    check("bp_drain", 36'(exp_q.size() + pend_q.size()), 36'd0);

    // Randomized streaming with random bubbles and backpressure.
    for (int i = 0; i < 400; i++) push_op(rand_op(), 0, '0);
    for (int i = 0; i < 1500 && (pend_q.size() > 0 || exp_q.size() > 0); i++)
      run_cycle(logic'($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0));
    check("rand_drain", 36'(exp_q.size() + pend_q.size()), 36'd0);

    // Reset with two operations in flight.
    push_op(rand_op(), 0, '0);
    push_op(rand_op(), 0, '0);
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("pre_rst_valid", 36'(out_valid), 36'd1);
    rst_n = 1'b0;
    #1;
    check("rst_flush_valid", 36'(out_valid), 36'd0);
    check("rst_flush_ready", 36'(in_ready), 36'd1);
    exp_q.delete();
    acc_q.delete();
    held_valid = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) run_cycle(1'b1, 1'b1);
    check("post_rst_ready", 36'(last_in_ready), 36'd1);
    check("post_rst_stale", 36'(out_valid), 36'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp32_mul_round_pack.md
Name: fp32_mul_round_pack

Overview:
- Downstream stage of the 24x24 mantissa multiplier in the FP32 multiply datapath.
- Consumes the 48-bit significand product, the pre-computed exponent sum, the result sign and the operand special-case flags.
- Normalises, rounds to nearest-even, handles overflow, underflow and special cases, and packs an IEEE-754 single result.
- Two-stage pipeline with a valid/ready handshake on both sides.

Parameters:
- EXP_W, 10, width of the signed two's-complement exponent-sum input.
- CANON_NAN, 32'h7FC00000, NaN encoding emitted for every NaN result.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream holds a valid operation.
- in_ready  out  1  stage can accept an operation this cycle.
- product  in  48  significand product with hidden bits included; normal operands give product[47] | product[46] = 1.
- exp_sum  in  EXP_W  ea + eb - 127, signed.
- sign  in  1  sign of the result (sa ^ sb).
- is_nan  in  1  either operand is NaN.
- is_inf  in  1  either operand is infinite.
- is_zero  in  1  either operand is zero; upstream has already flushed denormals to zero.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- result  out  32  packed FP32 result.
- flag_ovf  out  1  overflow.
- flag_unf  out  1  underflow.
- flag_inx  out  1  inexact.
- flag_inv  out  1  invalid operation.

Behaviour:
- Reset: while rst_n = 0, clear every register immediately (no clock needed). out_valid, result, all flags, s1_valid and s2_valid go to 0. in_ready = 1 after reset. Reset asserted mid-operation discards the in-flight operations; they are not replayed.
- Handshake:
  - Transfers occur on the rising edge when valid = 1 and ready = 1.
  - s2_en = ~s2_valid | out_ready.
  - s1_en = ~s1_valid | s2_en.
  - in_ready = s1_en, combinational; there is no ready-to-ready combinational path beyond this chain.
  - While out_valid = 1 and out_ready = 0, result and the flags stay stable.
  - Throughput is 1 operation per cycle. Latency from input accept to out_valid is exactly 2 cycles.
- Stage 1 (normalise), registered when s1_en:
  - If product[47] = 1: mant = product[46:24], guard = product[23], sticky = OR(product[22:0]), exp = exp_sum + 1.
  - Otherwise: mant = product[45:23], guard = product[22], sticky = OR(product[21:0]), exp = exp_sum.
  - Exp is carried at EXP_W + 1 bits, signed.
  - The special flags and sign are registered alongside.
  - If product[47:46] = 0 and no special flag is set, the operation is treated as zero (flag_unf = 1).
- Stage 2 (round and pack), registered when s2_en:
  - Round increment = guard & (sticky | mant[0]).
  - If mant + inc carries out of 23 bits: mant = 0, exp = exp + 1.
  - Special-case priority:
    1. is_nan, or is_inf & is_zero: result = CANON_NAN. flag_inv = 1 only for the inf*zero case.
    2. is_inf: result = {sign, 8'hFF, 23'h0}.
    3. is_zero: result = {sign, 31'h0}.
    4. exp >= 255 after rounding: result = {sign, 8'hFF, 0}, flag_ovf = 1, flag_inx = 1.
    5. exp <= 0 after rounding: result = {sign, 31'h0} (flush-to-zero), flag_unf = 1, flag_inx = 1.
    6. Otherwise: result = {sign, exp[7:0], mant}, flag_inx = guard | sticky.
  - Special cases 1-3 carry no ovf, unf or inx flags.
- Simultaneous events:
  - An input accepted in the same cycle stage 2 drains proceeds without a bubble.
  - A full pipeline with out_ready = 0 deasserts in_ready in that same cycle.

Test Plan:
- 1.5*1.5: product = 48'h900000000000, exp_sum = 127 -> result 32'h40100000 after 2 cycles, all flags 0.
- Tie to even, rounding up: product = 48'h400000C00000, exp_sum = 127 -> 32'h3F800002, flag_inx = 1. Tie to even, staying even: product = 48'h400000400000 -> 32'h3F800000, flag_inx = 1.
- Mantissa carry on rounding: product = 48'h7FFFFFFFFFFF, exp_sum = 127 -> 32'h40000000, flag_inx = 1. Overflow: product = 48'h800000000000, exp_sum = 254 -> 32'h7F800000, flag_ovf = 1, flag_inx = 1. Underflow: exp_sum = -1, sign = 1 -> 32'h80000000, flag_unf = 1.
- Specials: is_inf = 1 and is_zero = 1 -> 32'h7FC00000, flag_inv = 1. is_inf = 1, sign = 1 -> 32'hFF800000. is_nan = 1 -> 32'h7FC00000, flag_inv = 0.
- Backpressure: stream 4 operations back-to-back, out_ready = 0 for cycles 3-6. in_ready drops after 2 accepts. result holds stable while stalled. All 4 results emerge in order with no loss or duplication once out_ready = 1.
- Reset with 2 operations in flight: rst_n pulsed low between clock edges -> out_valid = 0 immediately. After release, in_ready = 1 and no stale result appears.
